prefetch_fetch: RTL and testbench

PREFETCH_FETCH -- requirements
Module: prefetch_fetch

---
 rtl/prefetch_fetch_if.sv | 20 ++
 rtl/prefetch_fetch.sv | 116 +++++++++++
 tb/tb_prefetch_fetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_fetch_if.sv
// Instruction-memory request bus between the prefetch unit (master) and memory (slave).
// Read data is valid in the same cycle as valid & ready.
interface prefetch_fetch_if;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_we;
    logic [31:0] imem_rdata;

    modport master (
        output imem_valid, imem_addr, imem_wdata, imem_we,
        input  imem_ready, imem_rdata
    );

    modport slave (
        input  imem_valid, imem_addr, imem_wdata, imem_we,
        output imem_ready, imem_rdata
    );
endinterface

// File: rtl/prefetch_fetch.sv
// Instruction prefetch unit: a two-state request FSM fills a DEPTH-entry FIFO of
// {address, word} pairs; a redirect flushes the FIFO and restarts fetching.
module prefetch_fetch #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0,
    parameter int          DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic                     retire_inst_i,
    input  logic [31:0]              target_addr_i,
    input  logic                     target_valid_i,
    output logic [31:0]              instr_o,
    output logic [31:0]              instr_addr_o,
    output logic                     instr_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    prefetch_fetch_if.master         imem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [31:0]     addr_q [DEPTH];
    logic [31:0]     addr_d [DEPTH];

    logic            handshake;
    logic            push;
    logic            pop;

    // A redirect wins over everything: a same-cycle handshake and retire are dropped.
    always_comb begin
        handshake  = (state_q == REQ) && imem.imem_ready;
        push       = handshake && !target_valid_i;
        pop        = retire_inst_i && (count_q != '0) && !target_valid_i;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        addr_d     = addr_q;

        if (target_valid_i) begin
            fetch_pc_d = target_addr_i & ~32'h3;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            state_d    = req_i ? REQ : IDLE;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = imem.imem_rdata;
                addr_d[wr_ptr_q] = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            // Leaving IDLE looks at pre-edge occupancy; staying in REQ looks at post-edge occupancy.
            case (state_q)
                IDLE: state_d = (req_i && (count_q < CW'(DEPTH))) ? REQ : IDLE;
                REQ: begin
                    if (handshake) begin
                        state_d = (req_i && (count_d < CW'(DEPTH))) ? REQ : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= BOOT_ADDRESS;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= BOOT_ADDRESS;
                addr_q[i] <= BOOT_ADDRESS;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
        end
    end

    assign imem.imem_valid = (state_q == REQ);
    assign imem.imem_addr  = fetch_pc_q;
    assign imem.imem_wdata = '0;
    assign imem.imem_we    = '0;

    assign instr_o       = data_q[rd_ptr_q];
    assign instr_addr_o  = addr_q[rd_ptr_q];
    assign instr_valid_o = (count_q != '0);
    assign count_o       = count_q;

endmodule

// File: tb/tb_prefetch_fetch.sv
// Directed bench for prefetch_fetch: a reference model with a scoreboard queue of
// expected {addr, word} pairs is stepped every clock and compared on the falling edge.
module tb_prefetch_fetch;

    localparam logic [31:0] BOOT  = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        retire_inst_i;
    logic [31:0] target_addr_i;
    logic        target_valid_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic [2:0]  count_o;

    prefetch_fetch_if bus ();

    prefetch_fetch #(.BOOT_ADDRESS(BOOT), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .retire_inst_i  (retire_inst_i),
        .target_addr_i  (target_addr_i),
        .target_valid_i (target_valid_i),
        .instr_o        (instr_o),
        .instr_addr_o   (instr_addr_o),
        .instr_valid_o  (instr_valid_o),
        .count_o        (count_o),
        .imem           (bus)
    );

    // Memory returns address + 1 so each word identifies where it was fetched from.
    assign bus.imem_rdata = bus.imem_addr + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_req;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_req = 1'b0;
        m_pc  = BOOT;
        m_q.delete();
    endtask

    task automatic modelStep();
        bit hs;
        int pre;
        hs  = m_req && bus.imem_ready;
        pre = m_q.size();
        if (target_valid_i) begin
            m_q.delete();
            m_pc  = target_addr_i & ~32'h3;
            m_req = req_i;
        end else begin
            if (retire_inst_i && m_q.size() > 0) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back({m_pc, m_pc + 32'd1});
                m_pc = m_pc + 32'd4;
            end
            if (!m_req) m_req = req_i && (pre < DEPTH);
            else if (hs) m_req = req_i && (m_q.size() < DEPTH);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, ":imem_valid"},  32'(bus.imem_valid), 32'(m_req));
        checkEq({tag, ":imem_addr"},   bus.imem_addr, m_pc);
        checkEq({tag, ":count"},       32'(count_o), 32'(m_q.size()));
        checkEq({tag, ":instr_valid"}, 32'(instr_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            checkEq({tag, ":instr_addr"}, instr_addr_o, m_q[0][63:32]);
            checkEq({tag, ":instr"},      instr_o,      m_q[0][31:0]);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic retire, input logic ready,
                                 input logic tv, input logic [31:0] tgt);
        req_i          = req;
        retire_inst_i  = retire;
        bus.imem_ready = ready;
        target_valid_i = tv;
        target_addr_i  = tgt;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        checkEq("reset:instr", instr_o, BOOT);
        checkEq("reset:instr_addr", instr_addr_o, BOOT);
        checkEq("reset:imem_addr", bus.imem_addr, BOOT);
        checkEq("reset:wdata", bus.imem_wdata, 32'h0);
        checkEq("reset:we", 32'(bus.imem_we), 32'h0);

        // Boot fetch and fill to full
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick("boot1");
        checkEq("boot1:imem_valid", 32'(bus.imem_valid), 32'd1);
        checkEq("boot1:imem_addr", bus.imem_addr, 32'h100);
        tick("boot2");
        checkEq("boot2:instr_valid", 32'(instr_valid_o), 32'd1);
        checkEq("boot2:instr_addr", instr_addr_o, 32'h100);
        checkEq("boot2:instr", instr_o, 32'h101);
        repeat (4) tick("fill");
        checkEq("full:count", 32'(count_o), 32'd4);
        checkEq("full:imem_valid", 32'(bus.imem_valid), 32'd0);
        checkEq("full:imem_addr", bus.imem_addr, 32'h110);

        // One retire frees one slot and yields exactly one request
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick("retire1");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick("refill_req");
        checkEq("refill:imem_addr", bus.imem_addr, 32'h110);
        checkEq("refill:imem_valid", 32'(bus.imem_valid), 32'd1);
        tick("refill_hs");
        tick("refill_idle");
        checkEq("refill:count", 32'(count_o), 32'd4);
        checkEq("refill:imem_valid_off", 32'(bus.imem_valid), 32'd0);
        checkEq("refill:head", instr_addr_o, 32'h104);

        // Drain, including a retire on an empty queue
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) tick("drain");
        checkEq("drain:count", 32'(count_o), 32'd0);

        // Stalled request holds while req_i drops
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick("stall_start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick("stall");
            checkEq("stall:imem_valid", 32'(bus.imem_valid), 32'd1);
            checkEq("stall:imem_addr", bus.imem_addr, 32'h114);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick("stall_hs");
        checkEq("stall_hs:imem_valid", 32'(bus.imem_valid), 32'd0);
        checkEq("stall_hs:count", 32'(count_o), 32'd1);
        checkEq("stall_hs:instr", instr_o, 32'h115);

        // Flush colliding with retire and handshake
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) tick("pre_flush");
        checkEq("pre_flush:count", 32'(count_o), 32'd3);
        checkEq("pre_flush:imem_addr", bus.imem_addr, 32'h120);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h2002);
        tick("flush");
        checkEq("flush:count", 32'(count_o), 32'd0);
        checkEq("flush:imem_addr", bus.imem_addr, 32'h2000);
        checkEq("flush:imem_valid", 32'(bus.imem_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick("post_flush");
        checkEq("post_flush:instr_addr", instr_addr_o, 32'h2000);
        checkEq("post_flush:instr", instr_o, 32'h2001);

        // Address wrap at the top of memory
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick("wrap_redirect");
        checkEq("wrap:imem_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick("wrap_hs");
        checkEq("wrap:imem_addr_zero", bus.imem_addr, 32'h0);
        checkEq("wrap:head", instr_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick("wrap_retire");
        tick("empty_retire");
        checkEq("empty_retire:count", 32'(count_o), 32'd0);

        // Asynchronous reset while a request is outstanding
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (4) tick("pre_reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkEq("async_rst:imem_valid", 32'(bus.imem_valid), 32'd0);
        checkEq("async_rst:instr_valid", 32'(instr_valid_o), 32'd0);
        checkEq("async_rst:count", 32'(count_o), 32'd0);
        checkEq("async_rst:imem_addr", bus.imem_addr, BOOT);
        checkOutput("async_rst");

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick("reboot1");
        checkEq("reboot:imem_valid", 32'(bus.imem_valid), 32'd1);
        tick("reboot2");
        checkEq("reboot:instr", instr_o, 32'h101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
